// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, word geometry,
// default address map.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned IDX_W             = $clog2(BYTES_PER_WORD);
    localparam int unsigned COUNT_W           = 10;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_ADDR_STEP = 32'd4;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-source, session-control and instruction-memory signals of the program loader.
interface prog_loader_if;

    logic                                 start;
    logic [prog_loader_pkg::COUNT_W-1:0]  word_count;
    logic                                 byte_valid;
    logic [7:0]                           byte_data;
    logic                                 byte_ready;
    logic                                 imem_wren;
    logic [31:0]                          imem_addr;
    logic [31:0]                          imem_wdata;
    logic                                 cpu_hold;
    logic                                 busy;
    logic                                 done;

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, imem_wren, imem_addr, imem_wdata, cpu_hold, busy, done
    );

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, imem_wren, imem_addr, imem_wdata, cpu_hold, busy, done
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Shifts accepted bytes in at the LSB end (MSB-first stream) and flags the last byte
// of each word.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
        end else if (i_accept) begin
            r_word <= {r_word[23:0], i_byte};
            r_idx  <= o_last ? '0 : r_idx + 1'b1;
        end
    end

    assign o_last = (r_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word = r_word;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: collects byte-serial instructions, writes them to
// instruction memory one word at a time and holds the CPU for the session.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic [31:0] ADDR_STEP = DEFAULT_ADDR_STEP
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);

    state_e             r_state;
    logic [COUNT_W-1:0] r_remaining;
    logic [31:0]        r_addr;
    logic               r_byte_ready;
    logic               r_wren;
    logic               r_hold;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_clear;
    logic               w_last;
    logic [31:0]        w_word;

    assign w_accept = r_byte_ready & bus.byte_valid;
    assign w_clear  = (r_state == StIdle) & bus.start;

    word_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_accept (w_accept),
        .i_byte   (bus.byte_data),
        .o_word   (w_word),
        .o_last   (w_last)
    );

    // Outputs are registered alongside the state so each one tracks its state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_remaining  <= '0;
            r_addr       <= BASE_ADDR;
            r_byte_ready <= 1'b0;
            r_wren       <= 1'b0;
            r_hold       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_remaining <= bus.word_count;
                        r_addr      <= BASE_ADDR;
                        r_hold      <= 1'b1;
                        r_busy      <= 1'b1;
                        if (bus.word_count == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= StCollect;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (w_accept && w_last) begin
                        r_state      <= StWrite;
                        r_byte_ready <= 1'b0;
                        r_wren       <= 1'b1;
                    end
                end
                StWrite: begin
                    r_wren      <= 1'b0;
                    r_addr      <= r_addr + ADDR_STEP;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == COUNT_W'(1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= StCollect;
                        r_byte_ready <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_hold  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.imem_wren  = r_wren;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_word;
    assign bus.cpu_hold   = r_hold;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: random byte streams and stalls, expected writes
// derived from word index and byte order, checked by a negedge monitor.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if if_a ();
    prog_loader_if if_b ();

    prog_loader #(.BASE_ADDR(32'h0), .ADDR_STEP(32'd4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    prog_loader #(.BASE_ADDR(BASE_B), .ADDR_STEP(32'd4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    int   wr_cyc_a[$];
    int   wr_cyc_b[$];
    int   wr_cnt[2];
    int   done_cnt[2];
    int   done_cyc[2];
    bit   hold_chk[2];
    bit   ready_seen[2];

    // byte source state
    int         sel = 0;
    logic [7:0] src_q[$];
    int         consumed = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    bit         rnd_stall = 0;
    bit         acc_pending = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %h, event not expected", name, got);
    endtask

    task automatic mon(input int d, input logic wren, input logic [31:0] addr,
                       input logic [31:0] data, input logic done, input logic hold,
                       input logic ready);
        exp_t e;
        if (wren) begin
            wr_cnt[d]++;
            if (d == 0) wr_cyc_a.push_back(cyc);
            else        wr_cyc_b.push_back(cyc);
            if ((d == 0 && sb_a.size() == 0) || (d == 1 && sb_b.size() == 0)) begin
                fail_now($sformatf("unexpected_write_dut%0d", d), addr);
            end else begin
                if (d == 0) e = sb_a.pop_front();
                else        e = sb_b.pop_front();
                chk($sformatf("wr_addr_dut%0d", d), addr, e.addr);
                chk($sformatf("wr_data_dut%0d", d), data, e.data);
            end
        end
        if (hold_chk[d]) begin
            chk($sformatf("hold_after_done_dut%0d", d), 32'(hold), 32'd0);
            chk($sformatf("done_one_cycle_dut%0d", d), 32'(done), 32'd0);
            hold_chk[d] = 1'b0;
        end
        if (done) begin
            chk($sformatf("hold_during_done_dut%0d", d), 32'(hold), 32'd1);
            done_cnt[d]++;
            done_cyc[d] = cyc;
            hold_chk[d] = 1'b1;
        end
        if (ready) ready_seen[d] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if_a.imem_wren, if_a.imem_addr, if_a.imem_wdata, if_a.done, if_a.cpu_hold,
                if_a.byte_ready);
            mon(1, if_b.imem_wren, if_b.imem_addr, if_b.imem_wdata, if_b.done, if_b.cpu_hold,
                if_b.byte_ready);
        end
    end

    // Source: real bytes when allowed, junk with valid only while ready is low.
    always @(negedge clk) begin
        logic       rdy;
        logic       v;
        logic [7:0] dat;
        if (acc_pending) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            consumed++;
        end
        acc_pending = 1'b0;
        rdy = (sel == 1) ? if_b.byte_ready : if_a.byte_ready;
        v   = 1'b0;
        dat = 8'($urandom);
        if (src_q.size() > 0) begin
            if (consumed == stall_at && stall_left > 0) stall_left--;
            else if (!(rnd_stall && $urandom_range(0, 2) == 0)) begin
                v   = 1'b1;
                dat = src_q[0];
            end
        end
        if (!v && !rdy && $urandom_range(0, 1) == 1) v = 1'b1;
        acc_pending = v && rdy;
        if (sel == 1) begin
            if_b.byte_valid = v;    if_b.byte_data = dat;
            if_a.byte_valid = 1'b0; if_a.byte_data = 8'h00;
        end else begin
            if_a.byte_valid = v;    if_a.byte_data = dat;
            if_b.byte_valid = 1'b0; if_b.byte_data = 8'h00;
        end
    end

    task automatic drive_start(input int d, input logic s, input logic [COUNT_W-1:0] wc);
        if (d == 1) begin if_b.start = s; if_b.word_count = wc; end
        else        begin if_a.start = s; if_a.word_count = wc; end
    endtask

    task automatic run_session(input int d, input int wc, input logic [7:0] bytes[$],
                               input int st_at, input int st_len, input bit rnd,
                               input bit mid_start, output int start_cyc);
        logic [31:0] base;
        exp_t        e;
        int          prev;
        int          n;
        int          budget;
        base = (d == 1) ? BASE_B : 32'h0;
        for (int i = 0; i < wc; i++) begin
            e.addr = base + 32'(i) * 32'd4;
            e.data = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            if (d == 1) sb_b.push_back(e);
            else        sb_a.push_back(e);
        end
        @(posedge clk);
        #1;
        sel = d; stall_at = st_at; stall_left = st_len; rnd_stall = rnd;
        src_q = bytes; consumed = 0;
        @(negedge clk);
        drive_start(d, 1'b1, COUNT_W'(wc));
        start_cyc = cyc;
        prev = done_cnt[d];
        @(negedge clk);
        drive_start(d, 1'b0, '0);
        if (mid_start) begin
            repeat (2) @(negedge clk);
            drive_start(d, 1'b1, COUNT_W'(5));
            @(negedge clk);
            drive_start(d, 1'b0, '0);
        end
        budget = wc * 12 + st_len + 100;
        n = 0;
        while (done_cnt[d] == prev && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt[d] == prev) fail_now("done_timeout", 32'(n));
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", (d == 1) ? 32'(sb_b.size()) : 32'(sb_a.size()), 32'd0);
        rnd_stall = 1'b0;
        stall_at  = -1;
    endtask

    initial begin
        logic [7:0] bq[$];
        int         sc;
        int         w0;
        int         n;
        int         wc;

        drive_start(0, 1'b0, '0);
        drive_start(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(if_a.byte_ready), 32'd0);
        chk("rst_wren",   32'(if_a.imem_wren), 32'd0);
        chk("rst_addr_a", if_a.imem_addr, 32'h0);
        chk("rst_addr_b", if_b.imem_addr, BASE_B);
        chk("rst_wdata",  if_a.imem_wdata, 32'h0);
        chk("rst_hold",   32'(if_a.cpu_hold), 32'd0);
        chk("rst_busy",   32'(if_a.busy), 32'd0);
        chk("rst_done",   32'(if_a.done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single word, back-to-back bytes
        bq = '{8'h20, 8'h22, 8'h00, 8'h01};
        w0 = wr_cnt[0];
        run_session(0, 1, bq, -1, 0, 1'b0, 1'b0, sc);
        chk("t1_writes", 32'(wr_cnt[0] - w0), 32'd1);
        chk("t1_wr_latency", 32'(wr_cyc_a[$] - sc), 32'd5);
        chk("t1_done_after_wr", 32'(done_cyc[0] - wr_cyc_a[$]), 32'd1);

        // three words, continuous
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        w0 = wr_cnt[0];
        run_session(0, 3, bq, -1, 0, 1'b0, 1'b0, sc);
        chk("t2_writes", 32'(wr_cnt[0] - w0), 32'd3);
        n = wr_cyc_a.size();
        chk("t2_gap1", 32'(wr_cyc_a[n-2] - wr_cyc_a[n-3]), 32'd5);
        chk("t2_gap2", 32'(wr_cyc_a[n-1] - wr_cyc_a[n-2]), 32'd5);

        // zero-length session
        bq.delete();
        w0 = wr_cnt[0];
        ready_seen[0] = 1'b0;
        run_session(0, 0, bq, -1, 0, 1'b0, 1'b0, sc);
        chk("t3_writes", 32'(wr_cnt[0] - w0), 32'd0);
        chk("t3_done_latency", 32'(done_cyc[0] - sc), 32'd1);
        chk("t3_ready_never", 32'(ready_seen[0]), 32'd0);

        // 7-cycle source stall after byte 2
        bq = '{8'h20, 8'h22, 8'h00, 8'h01};
        w0 = wr_cnt[0];
        run_session(0, 1, bq, 2, 7, 1'b0, 1'b0, sc);
        chk("t4_writes", 32'(wr_cnt[0] - w0), 32'd1);
        chk("t4_wr_latency", 32'(wr_cyc_a[$] - sc), 32'd12);

        // async reset after byte 2 of word 2: only word 0 may be written
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        sb_a.push_back('{addr: 32'h0, data: {bq[0], bq[1], bq[2], bq[3]}});
        w0 = wr_cnt[0];
        @(posedge clk);
        #1;
        sel = 0; stall_at = 6; stall_left = 100000; src_q = bq; consumed = 0;
        @(negedge clk);
        drive_start(0, 1'b1, COUNT_W'(3));
        @(negedge clk);
        drive_start(0, 1'b0, '0);
        n = 0;
        while (consumed < 6 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("t5_bytes_before_reset", 32'(consumed), 32'd6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(if_a.byte_ready), 32'd0);
        chk("t5_rst_wren",  32'(if_a.imem_wren), 32'd0);
        chk("t5_rst_addr",  if_a.imem_addr, 32'h0);
        chk("t5_rst_wdata", if_a.imem_wdata, 32'h0);
        chk("t5_rst_hold",  32'(if_a.cpu_hold), 32'd0);
        chk("t5_rst_busy",  32'(if_a.busy), 32'd0);
        chk("t5_rst_done",  32'(if_a.done), 32'd0);
        src_q.delete();
        acc_pending = 1'b0;
        stall_at = -1;
        stall_left = 0;
        hold_chk[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_write_after_reset", 32'(wr_cnt[0] - w0), 32'd1);
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        run_session(0, 1, bq, -1, 0, 1'b0, 1'b0, sc);
        chk("t5_reload_writes", 32'(wr_cnt[0] - w0), 32'd2);

        // address wrap on the high-base instance, with a stray start mid-session
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        w0 = wr_cnt[1];
        run_session(1, 2, bq, -1, 0, 1'b1, 1'b1, sc);
        repeat (20) @(negedge clk);
        chk("t6_writes", 32'(wr_cnt[1] - w0), 32'd2);

        // random sessions with random stalls, then a maximum-length session
        for (int s = 0; s < 6; s++) begin
            wc = $urandom_range(1, 8);
            bq.delete();
            for (int i = 0; i < 4 * wc; i++) bq.push_back(8'($urandom));
            w0 = wr_cnt[0];
            run_session(0, wc, bq, -1, 0, 1'b1, 1'b0, sc);
            chk("t7_writes", 32'(wr_cnt[0] - w0), 32'(wc));
        end
        bq.delete();
        for (int i = 0; i < 4 * 1023; i++) bq.push_back(8'($urandom));
        w0 = wr_cnt[0];
        run_session(0, 1023, bq, -1, 0, 1'b0, 1'b0, sc);
        chk("t8_max_writes", 32'(wr_cnt[0] - w0), 32'd1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
